// File: rtl/conv_mul_pkg.sv
// conv_mul_pkg: shared widths, tag-carrying stage record and clog2 helper for the shared multiplier
package conv_mul_pkg;
  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int TAG_W  = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  id;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } stage_t;
endpackage

// File: rtl/conv_mul_pipe.sv
// conv_mul_pipe: registered-operand 16x16 multiplier with valid/tag shift chain, frozen by ce
// Operand register, product register and trailing pipe registers line up with a DSP48's A/B, M and P stages.
module conv_mul_pipe
  import conv_mul_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int ID_W    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ce,
  input  logic               i_valid,
  input  logic [ID_W-1:0]    i_id,
  input  logic [DATA_W-1:0]  i_a,
  input  logic [DATA_W-1:0]  i_b,
  output logic [MUL_LAT-1:0] o_vld,
  output logic [ID_W-1:0]    o_id,
  output logic [PROD_W-1:0]  o_prod
);
  stage_t            r_s1;
  logic [PROD_W-1:0] w_p;
  logic              w_unused;
  assign w_p      = PROD_W'(r_s1.a) * PROD_W'(r_s1.b);
  assign w_unused = ^r_s1.id;
  always_ff @(posedge i_clk)
    if (i_rst) r_s1 <= '0;
    else if (i_ce) r_s1 <= '{valid: i_valid, id: TAG_W'(i_id), a: i_a, b: i_b};
  generate
    if (MUL_LAT == 1) begin : g_one
      assign o_vld  = r_s1.valid;
      assign o_id   = r_s1.id[ID_W-1:0];
      assign o_prod = w_p;
    end else begin : g_deep
      logic [MUL_LAT:2]  r_v;
      logic [ID_W-1:0]   r_id [2:MUL_LAT];
      logic [PROD_W-1:0] r_p  [2:MUL_LAT];
      always_ff @(posedge i_clk)
        if (i_rst) begin
          r_v  <= '0;
          r_id <= '{default: '0};
          r_p  <= '{default: '0};
        end else if (i_ce) begin
          r_v[2]  <= r_s1.valid;
          r_id[2] <= r_s1.id[ID_W-1:0];
          r_p[2]  <= w_p;
          for (int k = 3; k <= MUL_LAT; k++) begin
            r_v[k]  <= r_v[k-1];
            r_id[k] <= r_id[k-1];
            r_p[k]  <= r_p[k-1];
          end
        end
      assign o_vld  = {r_v, r_s1.valid};
      assign o_id   = r_id[MUL_LAT];
      assign o_prod = r_p[MUL_LAT];
    end
  endgenerate
endmodule

// File: rtl/conv_mul_arbiter.sv
// conv_mul_arbiter: round-robin issue of N_REQ requesters into one shared pipelined multiplier
// Responses return in issue order on a broadcast bus tagged with the requester index.
module conv_mul_arbiter
  import conv_mul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 3,
  parameter int ID_W    = clog2(N_REQ)
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    stall,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_data,
  output logic                    busy
);
  logic [ID_W-1:0]    r_ptr, w_idx, w_cand;
  logic               r_rst_q, w_found, w_issue;
  logic [MUL_LAT-1:0] w_vld;
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end
  // r_rst_q keeps grants off for the first cycle after reset as well
  assign w_issue   = w_found & ~stall & ~ap_rst & ~r_rst_q;
  assign req_ready = w_issue ? N_REQ'(1) << w_idx : '0;
  always_ff @(posedge ap_clk) begin
    r_rst_q <= ap_rst;
    if (ap_rst) r_ptr <= ID_W'(N_REQ - 1);
    else if (w_issue) r_ptr <= w_idx;
  end
  conv_mul_pipe #(.MUL_LAT(MUL_LAT), .ID_W(ID_W)) u_pipe (
    .i_clk  (ap_clk),
    .i_rst  (ap_rst),
    .i_ce   (~stall),
    .i_valid(w_issue),
    .i_id   (w_idx),
    .i_a    (req_a[DATA_W*w_idx +: DATA_W]),
    .i_b    (req_b[DATA_W*w_idx +: DATA_W]),
    .o_vld  (w_vld),
    .o_id   (rsp_id),
    .o_prod (rsp_data)
  );
  assign rsp_valid = w_vld[MUL_LAT-1] & ~stall & ~ap_rst;
  assign busy      = |w_vld;
endmodule

// File: tb/tb_conv_mul_arbiter.sv
// tb_conv_mul_arbiter: directed vectors plus an in-flight queue model checked every cycle
module tb_conv_mul_arbiter;
  localparam int N = 4;
  localparam int L = 3;
  logic        ap_clk = 0, ap_rst = 1, stall = 0;
  logic [3:0]  req_valid = 0, req_ready;
  logic [63:0] req_a = 0, req_b = 0;
  logic        rsp_valid, busy;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  int          n_pass = 0, n_tot = 0;
  bit          started = 0;
  int          m_last = N - 1;
  bit          m_rst_recent = 1;
  int          q_id[$];
  int          q_age[$];
  logic [31:0] q_p[$];

  always #5 ap_clk = ~ap_clk;

  conv_mul_arbiter #(.N_REQ(N), .MUL_LAT(L), .ID_W(2)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic lane(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  // Model: queue of in-flight products with their stage age; oldest presents at age L.
  initial begin
    wait (started);
    forever begin
      @(negedge ap_clk);
      begin
        int          g;
        logic [3:0]  er;
        bit          ev;
        logic [31:0] pa, pb;
        g  = (ap_rst || stall || m_rst_recent) ? -1 : pick();
        er = (g < 0) ? 4'b0 : 4'(1 << g);
        ev = !ap_rst && !stall && q_age.size() > 0 && q_age[0] == L;
        chk("onehot", 64'($onehot0(req_ready)), 1);
        chk("ready", req_ready, er);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
          chk("rsp_id", rsp_id, q_id[0]);
          chk("rsp_data", rsp_data, q_p[0]);
        end
        chk("busy", busy, q_age.size() > 0);
        if (ap_rst) begin
          q_id.delete();
          q_p.delete();
          q_age.delete();
          m_last = N - 1;
          m_rst_recent = 1;
        end else begin
          m_rst_recent = 0;
          if (!stall) begin
            if (ev) begin
              void'(q_id.pop_front());
              void'(q_p.pop_front());
              void'(q_age.pop_front());
            end
            foreach (q_age[i]) q_age[i]++;
            if (g >= 0) begin
              pa = 32'(req_a[16*g +: 16]);
              pb = 32'(req_b[16*g +: 16]);
              q_id.push_back(g);
              q_p.push_back(pa * pb);
              q_age.push_back(1);
              m_last = g;
            end
          end
        end
      end
    end
  end

  initial begin
    tick();
    started = 1;
    @(negedge ap_clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    tick();
    tick();
    // 1: first request after reset
    ap_rst = 0;
    req_valid = 4'b0001;
    lane(0, 3, 5);
    @(negedge ap_clk); chk("t1_ready_post_rst", req_ready, 0);
    tick();
    @(negedge ap_clk); chk("t1_grant", req_ready, 4'b0001);
    tick();
    req_valid = 0;
    tick();
    tick();
    @(negedge ap_clk);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_data", rsp_data, 15);
    tick();
    // 2: all four requesting continuously
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) lane(i, 16'(100 + i), 16'(10 + i));
    for (int k = 0; k < 8; k++) begin
      @(negedge ap_clk);
      if (k == 0) chk("t2_first_grant", req_ready, 4'b0010);
      if (k == 3) begin
        chk("t2_rsp_id_a", rsp_id, 1);
        chk("t2_rsp_data_a", rsp_data, 1111);
      end
      if (k == 4) begin
        chk("t2_rsp_id_b", rsp_id, 2);
        chk("t2_rsp_data_b", rsp_data, 1224);
      end
      if (k == 7) chk("t2_wrap_grant", req_ready, 4'b0001);
      tick();
    end
    req_valid = 0;
    repeat (4) tick();
    // 3: extreme operands
    req_valid = 4'b0001;
    lane(0, 16'hFFFF, 16'hFFFF);
    @(negedge ap_clk); chk("t3_grant_a", req_ready, 4'b0001);
    tick();
    lane(0, 0, 1234);
    @(negedge ap_clk); chk("t3_grant_b", req_ready, 4'b0001);
    tick();
    req_valid = 0;
    tick();
    @(negedge ap_clk); chk("t3_max_prod", rsp_data, 32'hFFFE0001);
    tick();
    @(negedge ap_clk);
    chk("t3_zero_valid", rsp_valid, 1);
    chk("t3_zero_prod", rsp_data, 0);
    tick();
    // 4: two stall cycles while req2 is in flight
    req_valid = 4'b0100;
    lane(2, 7, 9);
    @(negedge ap_clk); chk("t4_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0001;
    stall = 1;
    @(negedge ap_clk); chk("t4_stall_ready1", req_ready, 0); chk("t4_stall_rsp1", rsp_valid, 0);
    tick();
    @(negedge ap_clk); chk("t4_stall_ready2", req_ready, 0); chk("t4_stall_rsp2", rsp_valid, 0);
    tick();
    stall = 0;
    req_valid = 0;
    @(negedge ap_clk); chk("t4_rsp_t3", rsp_valid, 0);
    tick();
    @(negedge ap_clk); chk("t4_rsp_t4", rsp_valid, 0);
    tick();
    @(negedge ap_clk);
    chk("t4_rsp_t5", rsp_valid, 1);
    chk("t4_rsp_id", rsp_id, 2);
    chk("t4_rsp_data", rsp_data, 63);
    tick();
    @(negedge ap_clk); chk("t4_rsp_t6", rsp_valid, 0);
    tick();
    // 5: reset with three products in flight
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) lane(i, 16'(i + 1), 1000);
    @(negedge ap_clk); chk("t5_grant", req_ready, 4'b1000);
    tick();
    tick();
    tick();
    ap_rst = 1;
    @(negedge ap_clk); chk("t5_rst_rsp", rsp_valid, 0); chk("t5_rst_ready", req_ready, 0);
    tick();
    ap_rst = 0;
    @(negedge ap_clk);
    chk("t5_busy_clear", busy, 0);
    chk("t5_ready_post", req_ready, 0);
    chk("t5_rsp_post", rsp_valid, 0);
    tick();
    @(negedge ap_clk); chk("t5_grant_req0", req_ready, 4'b0001);
    tick();
    req_valid = 0;
    @(negedge ap_clk); chk("t5_no_rsp_a", rsp_valid, 0);
    tick();
    @(negedge ap_clk); chk("t5_no_rsp_b", rsp_valid, 0);
    tick();
    @(negedge ap_clk);
    chk("t5_new_rsp", rsp_valid, 1);
    chk("t5_new_id", rsp_id, 0);
    chk("t5_new_data", rsp_data, 1000);
    tick();
    // 6: only req1 and req3 compete
    req_valid = 4'b0010;
    lane(1, 5, 6);
    @(negedge ap_clk); chk("t6_g1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1010;
    lane(3, 7, 8);
    @(negedge ap_clk); chk("t6_g3a", req_ready, 4'b1000);
    tick();
    @(negedge ap_clk); chk("t6_g1b", req_ready, 4'b0010);
    tick();
    @(negedge ap_clk); chk("t6_g3b", req_ready, 4'b1000);
    tick();
    req_valid = 0;
    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
